// File: rtl/vga_ctrl_anim_if.sv
// Video memory and display-side signals of the animated VGA controller.
// master = controller (vga_ctrl_anim), slave = video memory / display sink.
interface vga_ctrl_anim_if;
  logic [9:0]  h_addr;
  logic [8:0]  v_addr;
  logic [9:0]  offset;
  logic [23:0] vga_data;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    output h_addr, v_addr, offset, hsync, vsync, valid, vga_r, vga_g, vga_b,
    input  vga_data
  );

  modport slave (
    input  h_addr, v_addr, offset, hsync, vsync, valid, vga_r, vga_g, vga_b,
    output vga_data
  );
endinterface

// File: rtl/vga_ctrl_anim.sv
// VGA timing generator with registered colour path and a bouncing sprite offset.
// Define VGA_ANIM_BOUNCE_EN to enable the offset animation; otherwise offset is 0.
module vga_ctrl_anim #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525,
  parameter int FRAME_DIV = 1,
  parameter int OFF_MAX   = 352
) (
  input logic             pclk,
  input logic             rst_n,
  vga_ctrl_anim_if.master vif
);

  localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);

  if (FRAME_DIV < 1 || FRAME_DIV > 255 || OFF_MAX < 1 || OFF_MAX > 1023) begin : g_cfg_check
    $error("vga_ctrl_anim: FRAME_DIV must be 1..255 and OFF_MAX 1..1023");
  end

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_end, v_end, active;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        vld_p1_q, vld_p1_d;
  logic [23:0] rgb_p1_q, rgb_p1_d;

  always_comb begin
    h_end   = (h_cnt_q == H_LAST);
    v_end   = (v_cnt_q == V_LAST);
    h_cnt_d = h_end ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_end) v_cnt_d = v_end ? '0 : v_cnt_q + 10'd1;
    active  = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) &&
              (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
    hsync_d  = (h_cnt_q >= H_SW);
    vsync_d  = (v_cnt_q >= V_SW);
    vld_p1_d = active;
    rgb_p1_d = active ? vif.vga_data : '0;
  end

  // Addresses are zero-latency so memory data lands in the same cycle.
  assign vif.h_addr = active ? h_cnt_q - H_LO : '0;
  assign vif.v_addr = active ? 9'(v_cnt_q - V_LO) : '0;

  // ---- stage p1: sync, valid and colour registered together ----
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vld_p1_q <= 1'b0;
      rgb_p1_q <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vld_p1_q <= vld_p1_d;
      rgb_p1_q <= rgb_p1_d;
    end
  end

  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
  assign vif.valid = vld_p1_q;
  assign vif.vga_r = rgb_p1_q[23:16];
  assign vif.vga_g = rgb_p1_q[15:8];
  assign vif.vga_b = rgb_p1_q[7:0];

`ifdef VGA_ANIM_BOUNCE_EN
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [9:0] OFF_TOP   = 10'(OFF_MAX);
  localparam logic [7:0] FDIV_LAST = 8'(FRAME_DIV - 1);

  dir_e       state_q, state_d;
  logic [7:0] fdiv_q, fdiv_d;
  logic [9:0] offset_q, offset_d;
  logic       frame_end, step;

  // Turning at an end reflects immediately, so the ends are held for one step only.
  function automatic logic [9:0] step_offset(input dir_e dir, input logic [9:0] off);
    if (dir == UP) return (off < OFF_TOP) ? off + 10'd1 : off - 10'd1;
    else           return (off != '0)     ? off - 10'd1 : off + 10'd1;
  endfunction

  assign frame_end = h_end && v_end;
  assign step      = frame_end && (fdiv_q == FDIV_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UP;
      fdiv_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      fdiv_q   <= fdiv_d;
      offset_q <= offset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (step) begin
      if (state_q == UP && offset_q == OFF_TOP) state_d = DOWN;
      if (state_q == DOWN && offset_q == '0)    state_d = UP;
    end
  end

  always_comb begin
    fdiv_d   = fdiv_q;
    offset_d = offset_q;
    if (frame_end) fdiv_d = (fdiv_q == FDIV_LAST) ? '0 : fdiv_q + 8'd1;
    if (step)      offset_d = step_offset(state_q, offset_q);
  end

  assign vif.offset = offset_q;
`else
  assign vif.offset = '0;
`endif

endmodule

// File: tb/tb_vga_ctrl_anim.sv
// Scoreboard bench for vga_ctrl_anim using shrunk timing; the reference model
// derives every output from the elapsed pixel count since reset release.
module tb_vga_ctrl_anim;
  localparam int HS = 4, HB = 3, HA = 10, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5,  VT = 12;
  localparam int FD = 2, OM = 3;
  localparam int FT = HT * VT;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  vga_ctrl_anim_if vif();

  vga_ctrl_anim #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .FRAME_DIV(FD), .OFF_MAX(OM)
  ) dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .vif  (vif)
  );

  logic [23:0] lut [1024];

  function automatic logic [23:0] pattern(input logic [9:0] h, input logic [8:0] v);
    return lut[h] ^ (24'(v) * 24'h010101);
  endfunction

  assign vif.vga_data = pattern(vif.h_addr, vif.v_addr);

  typedef struct {
    logic [9:0]  h_addr;
    logic [8:0]  v_addr;
    logic        hs, vs, vld;
    logic [23:0] rgb;
    logic [9:0]  off;
  } exp_t;

  exp_t q[$];
  int   n = 0;
  int   checks = 0;
  int   fails = 0;

  function automatic bit is_act(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  // Expected outputs after the n-th clock edge since reset release.
  function automatic exp_t model(input int cyc);
    exp_t e;
    int pr = cyc - 1;
    int k, ph;
    e.h_addr = is_act(cyc) ? 10'((cyc % HT) - (HS + HB)) : 10'd0;
    e.v_addr = is_act(cyc) ? 9'(((cyc / HT) % VT) - (VS + VB)) : 9'd0;
    e.hs  = ((pr % HT) >= HS);
    e.vs  = (((pr / HT) % VT) >= VS);
    e.vld = is_act(pr);
    e.rgb = is_act(pr) ? pattern(10'((pr % HT) - (HS + HB)), 9'(((pr / HT) % VT) - (VS + VB)))
                       : 24'd0;
`ifdef VGA_ANIM_BOUNCE_EN
    k  = (cyc / FT) / FD;
    ph = k % (2 * OM);
    e.off = 10'((ph <= OM) ? ph : 2 * OM - ph);
`else
    k  = 0;
    ph = k;
    e.off = 10'(ph);
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_h_addr"}, 32'(vif.h_addr), 32'd0);
    chk({tag, "_v_addr"}, 32'(vif.v_addr), 32'd0);
    chk({tag, "_hsync"},  32'(vif.hsync),  32'd1);
    chk({tag, "_vsync"},  32'(vif.vsync),  32'd1);
    chk({tag, "_valid"},  32'(vif.valid),  32'd0);
    chk({tag, "_rgb"},    32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'd0);
    chk({tag, "_offset"}, 32'(vif.offset), 32'd0);
  endtask

  // Stimulus side: every edge after release pushes the expected response.
  initial begin
    forever begin
      @(posedge pclk);
      if (!rst_n) n = 0;
      else begin
        n++;
        q.push_back(model(n));
      end
    end
  end

  // Monitor side: sample half a cycle after the edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!rst_n) q.delete();
      else if (q.size() > 0) begin
        e = q.pop_front();
        chk("h_addr", 32'(vif.h_addr), 32'(e.h_addr));
        chk("v_addr", 32'(vif.v_addr), 32'(e.v_addr));
        chk("hsync",  32'(vif.hsync),  32'(e.hs));
        chk("vsync",  32'(vif.vsync),  32'(e.vs));
        chk("valid",  32'(vif.valid),  32'(e.vld));
        chk("rgb",    32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(e.rgb));
        chk("offset", 32'(vif.offset), 32'(e.off));
      end
    end
  end

  initial begin
    int target;
    for (int i = 0; i < 1024; i++) lut[i] = 24'($urandom);
    rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    #1 chk_reset("init_rst");
    #1 rst_n = 1'b1;

    repeat (14 * FT) @(posedge pclk);

    // Reset in the middle of a visible line of a later frame.
    target = 6 * HT + 12;
    for (int i = 0; i < FT + 1 && (n % FT) != target; i++) @(posedge pclk);
    chk("mid_rst_reached", 32'(n % FT), 32'(target));
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    repeat (2) @(negedge pclk);
    #1 chk_reset("mid_rst_hold");
    #1 rst_n = 1'b1;

    repeat (3 * FT) @(posedge pclk);
    @(negedge pclk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_ctrl_anim.md
VGA_CTRL_ANIM -- requirements
Module: vga_ctrl_anim

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: hsync pulse width, pixels.
REQ-002 SHALL have parameter H_BACK, default 48: horizontal back porch, pixels.
REQ-003 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-005 SHALL have parameter V_SYNC, V_BACK, V_ACTIVE, V_TOTAL, defaults 2, 33, 480, 525: vertical equivalents, in lines.
REQ-006 SHALL have parameter FRAME_DIV, default 1: frames per offset step, range 1..255.
REQ-007 SHALL have parameter OFF_MAX, default 352: maximum sprite offset.
REQ-008 pclk  in  1: pixel clock, all logic on rising edge.
REQ-009 rst_n  in  1: reset, asynchronous, active-low.
REQ-010 h_addr  out  10: current visible column; 0 outside active area.
REQ-011 v_addr  out  9: current visible row; 0 outside active area.
REQ-012 vga_data  in  24: pixel {R,G,B} from video memory, combinational response to h_addr/v_addr.
REQ-013 offset  out  10: sprite offset driven to video memory.
REQ-014 hsync  out  1: horizontal sync, active-low.
REQ-015 vsync  out  1: vertical sync, active-low.
REQ-016 valid  out  1: high when vga_r/g/b carry a visible pixel.
REQ-017 vga_r, vga_g, vga_b  out  8 each: colour outputs.

Function
REQ-018 h_cnt (10 b) SHALL increment each pclk and wrap from H_TOTAL-1 to 0.
REQ-019 v_cnt (10 b) SHALL increment only when h_cnt wraps, and wrap from V_TOTAL-1 to 0.
REQ-020 Horizontal active SHALL be H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE (144..783 default); vertical active likewise (35..514 default).
REQ-021 h_addr = h_cnt-(H_SYNC+H_BACK), v_addr = v_cnt-(V_SYNC+V_BACK) when both active, else 0; combinational from counters (zero latency).
REQ-022 Raw sync SHALL be low when h_cnt < H_SYNC (resp. v_cnt < V_SYNC).
REQ-023 hsync, vsync, valid SHALL be registered copies of raw sync/active, one pclk after h_addr/v_addr.
REQ-024 {vga_r,vga_g,vga_b} SHALL register vga_data[23:16], [15:8], [7:0] when active, else register 0; latency exactly 1 pclk, aligned with valid.
REQ-025 Frame end SHALL be the cycle with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
REQ-026 offset SHALL change only on the pclk edge at frame end; never mid-frame.
REQ-027 Frame divider fdiv SHALL count frame ends 0..FRAME_DIV-1; an offset step occurs on the frame end where fdiv==FRAME_DIV-1, then fdiv returns to 0.
REQ-028 Direction FSM SHALL have states UP and DOWN.
REQ-029 UP step: offset<OFF_MAX -> offset+1; offset==OFF_MAX -> offset-1 and go DOWN.
REQ-030 DOWN step: offset>0 -> offset-1; offset==0 -> offset+1 and go UP.
REQ-031 offset SHALL never exceed OFF_MAX nor underflow below 0.

Reset
REQ-032 While rst_n low: h_cnt=0, v_cnt=0, fdiv=0, offset=0, state UP, hsync=1, vsync=1, valid=0, vga_r/g/b=0.
REQ-033 Reset deassertion mid-frame SHALL restart timing at h_cnt=0, v_cnt=0; first hsync low one pclk after first post-reset edge.

Configuration
REQ-034 Macro VGA_ANIM_BOUNCE_EN defined: offset, fdiv and FSM behave per REQ-026..031.
REQ-035 VGA_ANIM_BOUNCE_EN undefined: offset tied to 0, fdiv and FSM not instantiated; timing and colour path unchanged.

Verification
REQ-036 Reset release, run 1 line -> hsync low exactly 96 pclk, line period 800 pclk, valid high 640 pclk per visible line.
REQ-037 Run 1 frame -> vsync low 2 lines, frame period 420000 pclk, 480 lines with valid.
REQ-038 vga_data = h_addr-derived pattern -> vga_r/g/b equal data of previous-cycle address; 0 whenever valid low.
REQ-039 BOUNCE_EN, FRAME_DIV=1 -> offset 0,1,2 on successive frames; after 352 frames offset=352, next frame 351; at 0 in DOWN, next 1.
REQ-040 FRAME_DIV=4 -> offset increments once per 4 frames, only at frame-end edge.
REQ-041 Assert rst_n low at h_cnt=400, v_cnt=200 -> outputs at reset values immediately; after release counters from 0, offset 0.
